// File: rtl/color_sense_if.sv
// color_sense_if: sensor-side inputs and classification results of color_sense_mc.
// cnt_c_o exists only when COLOR_CLEAR_EN is defined.
interface color_sense_if #(
  parameter int unsigned CNT_W = 20
);
  logic             out_i;
  logic             en_i;
  logic             s2_o;
  logic             s3_o;
  logic [1:0]       color_o;
  logic             valid_o;
  logic [CNT_W-1:0] cnt_r_o;
  logic [CNT_W-1:0] cnt_g_o;
  logic [CNT_W-1:0] cnt_b_o;
`ifdef COLOR_CLEAR_EN
  logic [CNT_W-1:0] cnt_c_o;

  modport master (output out_i, en_i,
                  input  s2_o, s3_o, color_o, valid_o, cnt_r_o, cnt_g_o, cnt_b_o, cnt_c_o);
  modport slave  (input  out_i, en_i,
                  output s2_o, s3_o, color_o, valid_o, cnt_r_o, cnt_g_o, cnt_b_o, cnt_c_o);
`else
  modport master (output out_i, en_i,
                  input  s2_o, s3_o, color_o, valid_o, cnt_r_o, cnt_g_o, cnt_b_o);
  modport slave  (input  out_i, en_i,
                  output s2_o, s3_o, color_o, valid_o, cnt_r_o, cnt_g_o, cnt_b_o);
`endif
endinterface

// File: rtl/color_sense_mc.sv
// color_sense_mc: TCS3200 colour classifier cycling R/B/G filter phases and reporting the dominant colour.
// Defining COLOR_CLEAR_EN adds a clear-channel phase, the cnt_c_o output and an ambient-light check.
module color_sense_mc #(
  parameter int unsigned GATE_CYCLES   = 500000,
  parameter int unsigned SETTLE_CYCLES = 5000,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned MIN_CNT       = 50
) (
  input  logic         clk,
  input  logic         rst_n,
  color_sense_if.slave bus
);
  localparam int unsigned MAX_T = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W = $clog2(MAX_T + 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DECIDE} state_t;
  typedef enum logic [1:0] {PH_R, PH_B, PH_G, PH_C} phase_t;

`ifdef COLOR_CLEAR_EN
  localparam phase_t PH_LAST = PH_C;
`else
  localparam phase_t PH_LAST = PH_G;
`endif

  state_t           state_q;
  phase_t           phase_q;
  logic [TMR_W-1:0] tmr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q, prev_q, rise_c;
  logic [CNT_W-1:0] hold_r_q, hold_b_q;
  logic [1:0]       sel_q, color_q, color_d;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_r_q, cnt_g_q, cnt_b_q;
  logic [CNT_W-1:0] r_eff, g_eff, b_eff, max_v;
`ifdef COLOR_CLEAR_EN
  logic [CNT_W-1:0] hold_g_q, cnt_c_q, c_eff;
`endif

  // {s2, s3} filter select per phase
  function automatic logic [1:0] sel_f(input phase_t p);
    case (p)
      PH_R:    sel_f = 2'b00;
      PH_B:    sel_f = 2'b01;
      PH_G:    sel_f = 2'b11;
      default: sel_f = 2'b10;
    endcase
  endfunction

  function automatic phase_t next_f(input phase_t p);
    case (p)
      PH_R:    next_f = PH_B;
      PH_B:    next_f = PH_G;
      PH_G:    next_f = PH_C;
      default: next_f = PH_R;
    endcase
  endfunction

  assign rise_c = sync2_q & ~prev_q;
  assign cnt_d  = (rise_c && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  // The last phase's count is still in cnt_d when the decision is registered.
  always_comb begin
    r_eff = hold_r_q;
    b_eff = hold_b_q;
`ifdef COLOR_CLEAR_EN
    g_eff = hold_g_q;
    c_eff = cnt_d;
`else
    g_eff = cnt_d;
`endif
    color_d = 2'b01;
    max_v   = r_eff;
    if (g_eff > max_v) begin
      color_d = 2'b10;
      max_v   = g_eff;
    end
    if (b_eff > max_v) begin
      color_d = 2'b11;
      max_v   = b_eff;
    end
    if (32'(max_v) < MIN_CNT) color_d = 2'b00;
`ifdef COLOR_CLEAR_EN
    if (32'(c_eff) < MIN_CNT) color_d = 2'b00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_R;
      tmr_q    <= '0;
      cnt_q    <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      hold_r_q <= '0;
      hold_b_q <= '0;
      sel_q    <= 2'b00;
      color_q  <= 2'b00;
      valid_q  <= 1'b0;
      cnt_r_q  <= '0;
      cnt_g_q  <= '0;
      cnt_b_q  <= '0;
`ifdef COLOR_CLEAR_EN
      hold_g_q <= '0;
      cnt_c_q  <= '0;
`endif
    end else begin
      sync1_q <= bus.out_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          tmr_q <= '0;
          cnt_q <= '0;
          if (bus.en_i) begin
            state_q <= S_SETTLE;
            phase_q <= PH_R;
            sel_q   <= sel_f(PH_R);
          end
        end
        S_SETTLE: begin
          cnt_q <= '0;
          if (!bus.en_i) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            sel_q   <= 2'b00;
          end else if (tmr_q == SETTLE_LAST) begin
            tmr_q   <= '0;
            state_q <= S_COUNT;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_COUNT: begin
          if (!bus.en_i) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
          end else if (tmr_q == GATE_LAST) begin
            tmr_q <= '0;
            cnt_q <= '0;
            case (phase_q)
              PH_R: hold_r_q <= cnt_d;
              PH_B: hold_b_q <= cnt_d;
`ifdef COLOR_CLEAR_EN
              PH_G: hold_g_q <= cnt_d;
`endif
              default: ;
            endcase
            if (phase_q == PH_LAST) begin
              state_q <= S_DECIDE;
              sel_q   <= 2'b00;
              valid_q <= 1'b1;
              color_q <= color_d;
              cnt_r_q <= r_eff;
              cnt_g_q <= g_eff;
              cnt_b_q <= b_eff;
`ifdef COLOR_CLEAR_EN
              cnt_c_q <= c_eff;
`endif
            end else begin
              state_q <= S_SETTLE;
              phase_q <= next_f(phase_q);
              sel_q   <= sel_f(next_f(phase_q));
            end
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
            cnt_q <= cnt_d;
          end
        end
        S_DECIDE: begin
          if (bus.en_i) begin
            state_q <= S_SETTLE;
            phase_q <= PH_R;
            sel_q   <= sel_f(PH_R);
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.s2_o    = sel_q[1];
  assign bus.s3_o    = sel_q[0];
  assign bus.color_o = color_q;
  assign bus.valid_o = valid_q;
  assign bus.cnt_r_o = cnt_r_q;
  assign bus.cnt_g_o = cnt_g_q;
  assign bus.cnt_b_o = cnt_b_q;
`ifdef COLOR_CLEAR_EN
  assign bus.cnt_c_o = cnt_c_q;
`endif
endmodule

// File: tb/tb_color_sense_mc.sv
// tb_color_sense_mc: drives two classifiers (20-bit and 4-bit counters) with a shared sensor waveform.
// Optional COLOR_CLEAR_EN build adds the clear phase and ambient check.
module tb_color_sense_mc;
  localparam int G    = 100;
  localparam int S    = 10;
  localparam int MINC = 5;
  localparam int WA   = 20;
  localparam int WB   = 4;
`ifdef COLOR_CLEAR_EN
  localparam int NPH = 4;
`else
  localparam int NPH = 3;
`endif
  localparam int PH_LEN = S + G;
  localparam int FRAME  = NPH * PH_LEN;

  typedef struct {
    int         kr;
    int         kb;
    int         kg;
    int         kc;
    logic [1:0] col;
  } vec_t;

  logic clk, rst_n, out_s, en_s;
  int   n_chk, n_fail;
  int   kph[4];
  int   stph[4];
  logic [1:0] lcol[2];
  int   lr[2], lg[2], lb[2];
  vec_t tab[8];

  color_sense_if #(.CNT_W(WA)) bus_a ();
  color_sense_if #(.CNT_W(WB)) bus_b ();

  assign bus_a.out_i = out_s;
  assign bus_a.en_i  = en_s;
  assign bus_b.out_i = out_s;
  assign bus_b.en_i  = en_s;

  color_sense_mc #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(WA), .MIN_CNT(MINC)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  color_sense_mc #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(WB), .MIN_CNT(MINC)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int k, input int w);
    int m;
    m = (1 << w) - 1;
    return (k > m) ? m : k;
  endfunction

  // Reference classification: largest count wins, R before G before B on ties.
  function automatic logic [1:0] model(input int r, input int g, input int b, input int c);
    int m;
    m = r;
    if (g > m) m = g;
    if (b > m) m = b;
    if (m < MINC) return 2'b00;
    if (NPH == 4 && c < MINC) return 2'b00;
    if (r == m) return 2'b01;
    if (g == m) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [1:0] selof(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Sensor waveform: kph[ph] pulses (2 high, 2 low) starting stph[ph] cycles into the count window.
  function automatic logic gen(input int ph, input int off);
    int d;
    d = off - stph[ph];
    return (off >= 0) && (d >= 0) && (d < 4 * kph[ph]) && ((d % 4) < 2);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid_a"}, bus_a.valid_o, 0);
    chk({tag, "_color_a"}, bus_a.color_o, 0);
    chk({tag, "_cnt_r_a"}, bus_a.cnt_r_o, 0);
    chk({tag, "_cnt_g_a"}, bus_a.cnt_g_o, 0);
    chk({tag, "_cnt_b_a"}, bus_a.cnt_b_o, 0);
    chk({tag, "_sel_a"}, {bus_a.s2_o, bus_a.s3_o}, 0);
    chk({tag, "_valid_b"}, bus_b.valid_o, 0);
    chk({tag, "_color_b"}, bus_b.color_o, 0);
    chk({tag, "_cnt_r_b"}, bus_b.cnt_r_o, 0);
    chk({tag, "_sel_b"}, {bus_b.s2_o, bus_b.s3_o}, 0);
`ifdef COLOR_CLEAR_EN
    chk({tag, "_cnt_c_a"}, bus_a.cnt_c_o, 0);
`endif
  endtask

  task automatic clear_last();
    for (int i = 0; i < 2; i++) begin
      lcol[i] = 2'b00;
      lr[i] = 0;
      lg[i] = 0;
      lb[i] = 0;
    end
  endtask

  // Entered just after a clock edge with en_s already high; the next edge starts SETTLE.
  task automatic run_frame(input bit keep_en, input logic [1:0] ea_col,
                           input int ea_r, input int ea_b, input int ea_g, input int ea_c);
    int ph;
    logic [1:0] eb_col;
    for (int j = 0; j <= FRAME; j++) begin
      @(posedge clk);
      #1;
      if (j < FRAME) begin
        ph = j / PH_LEN;
        out_s = gen(ph, (j % PH_LEN) - S);
        chk("valid_early_a", bus_a.valid_o, 0);
        chk("valid_early_b", bus_b.valid_o, 0);
        chk("sel_a", {bus_a.s2_o, bus_a.s3_o}, selof(ph));
        chk("sel_b", {bus_b.s2_o, bus_b.s3_o}, selof(ph));
        chk("color_hold_a", bus_a.color_o, lcol[0]);
        chk("color_hold_b", bus_b.color_o, lcol[1]);
      end else begin
        out_s = 1'b0;
        if (!keep_en) en_s = 1'b0;
        eb_col = model(sat(kph[0], WB), sat(kph[2], WB), sat(kph[1], WB), sat(kph[3], WB));
        chk("valid_a", bus_a.valid_o, 1);
        chk("valid_b", bus_b.valid_o, 1);
        chk("color_a", bus_a.color_o, ea_col);
        chk("cnt_r_a", bus_a.cnt_r_o, ea_r);
        chk("cnt_g_a", bus_a.cnt_g_o, ea_g);
        chk("cnt_b_a", bus_a.cnt_b_o, ea_b);
        chk("color_b", bus_b.color_o, eb_col);
        chk("cnt_r_b", bus_b.cnt_r_o, sat(kph[0], WB));
        chk("cnt_g_b", bus_b.cnt_g_o, sat(kph[2], WB));
        chk("cnt_b_b", bus_b.cnt_b_o, sat(kph[1], WB));
`ifdef COLOR_CLEAR_EN
        chk("cnt_c_a", bus_a.cnt_c_o, ea_c);
        chk("cnt_c_b", bus_b.cnt_c_o, sat(kph[3], WB));
`else
        if (ea_c < 0) chk("cnt_c_arg", ea_c, 0);
`endif
        lcol[0] = ea_col;
        lr[0] = ea_r;
        lg[0] = ea_g;
        lb[0] = ea_b;
        lcol[1] = eb_col;
        lr[1] = sat(kph[0], WB);
        lg[1] = sat(kph[2], WB);
        lb[1] = sat(kph[1], WB);
      end
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk({tag, "_valid_a"}, bus_a.valid_o, 0);
      chk({tag, "_sel_a"}, {bus_a.s2_o, bus_a.s3_o}, 0);
      chk({tag, "_color_a"}, bus_a.color_o, lcol[0]);
      chk({tag, "_color_b"}, bus_b.color_o, lcol[1]);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    en_s = 1'b0;
    out_s = 1'b0;
    kph = '{0, 0, 0, 0};
    stph = '{0, 0, 0, 0};
    clear_last();

    //            kr  kb  kg  kc  colour
    tab[0] = '{25,  0,  0, 25, 2'b01};
    tab[1] = '{20, 20, 20, 25, 2'b01};
    tab[2] = '{ 0, 20, 20, 25, 2'b10};
    tab[3] = '{ 4,  4,  4, 25, 2'b00};
    tab[4] = '{ 3, 22, 10, 25, 2'b11};
    tab[5] = '{10, 10, 25, 25, 2'b10};
    tab[6] = '{ 5,  0,  0, 25, 2'b01};
    tab[7] = '{ 0,  0,  0, 25, 2'b00};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle_check(5, "idle");

    // Table-driven frames, back to back
    en_s = 1'b1;
    foreach (tab[i]) begin
      kph = '{tab[i].kr, tab[i].kb, tab[i].kg, tab[i].kc};
      stph = '{0, 0, 0, 0};
      run_frame(i != 7, tab[i].col, tab[i].kr, tab[i].kb, tab[i].kg, tab[i].kc);
    end
    idle_check(20, "after_tab");

    // Randomized frames against the reference model
    en_s = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 4; p++) begin
        kph[p] = int'($urandom_range(0, 24));
        stph[p] = int'($urandom_range(0, 32'(G - 4 - 4 * (kph[p] > 0 ? kph[p] - 1 : 0))));
      end
      run_frame(r != 5, model(kph[0], kph[2], kph[1], kph[3]),
                kph[0], kph[1], kph[2], kph[3]);
    end
    idle_check(10, "after_rand");

    // en dropped during the G count window: abort, no valid, previous results held
    kph = '{25, 0, 0, 25};
    stph = '{0, 0, 0, 0};
    en_s = 1'b1;
    run_frame(1'b0, 2'b01, 25, 0, 0, 25);
    idle_check(3, "pre_abort");
    kph = '{12, 7, 18, 25};
    en_s = 1'b1;
    for (int j = 0; j <= 2 * PH_LEN + S + 40; j++) begin
      @(posedge clk);
      #1;
      out_s = gen(j / PH_LEN, (j % PH_LEN) - S);
    end
    chk("abort_sel_g", {bus_a.s2_o, bus_a.s3_o}, 2'b11);
    en_s = 1'b0;
    out_s = 1'b0;
    idle_check(FRAME + 20, "abort");
    chk("abort_cnt_r_a", bus_a.cnt_r_o, lr[0]);
    chk("abort_cnt_g_a", bus_a.cnt_g_o, lg[0]);
    chk("abort_cnt_b_a", bus_a.cnt_b_o, lb[0]);
    chk("abort_cnt_r_b", bus_b.cnt_r_o, lr[1]);

    // Reset asserted mid-COUNT with out toggling, then a full frame is required for valid
    kph = '{25, 0, 0, 25};
    en_s = 1'b1;
    for (int j = 0; j <= S + 50; j++) begin
      @(posedge clk);
      #1;
      out_s = gen(j / PH_LEN, (j % PH_LEN) - S);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    clear_last();
    out_s = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    kph = '{0, 12, 18, 25};
    run_frame(1'b0, 2'b10, 0, 12, 18, 25);
    idle_check(5, "after_rst");

`ifdef COLOR_CLEAR_EN
    // Clear channel below threshold forces "none" despite a strong red count
    kph = '{25, 0, 0, 0};
    en_s = 1'b1;
    run_frame(1'b0, 2'b00, 25, 0, 0, 0);
    idle_check(5, "after_amb");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/color_sense_mc.md
# color_sense_mc

Multi-channel colour classifier for a TCS3200-class light-to-frequency sensor on the line-follower. Drives the sensor's photodiode filter select (s2/s3) through red, blue and green phases. Counts synchronised rising edges of the sensor output over a programmable gate window per phase, then reports the dominant colour with a one-cycle valid strobe. Downstream path-planning logic consumes `color`/`valid`; the raw per-channel counts are exported for calibration.

## Interface
- `GATE_CYCLES`, 500000, clk cycles per counting window (10 ms at 50 MHz); ≥1
- `SETTLE_CYCLES`, 5000, clk cycles after a filter change before counting starts; ≥1
- `CNT_W`, 20, edge-counter width
- `MIN_CNT`, 50, minimum winning count for a valid colour, else "none"
- `clk` in 1 system clock; all logic on rising edge
- `rst_n` in 1 asynchronous, active-low reset
- `out` in 1 sensor frequency output, asynchronous to clk
- `en` in 1 level enable; frames run back-to-back while high
- `s2` out 1 filter select bit
- `s3` out 1 filter select bit
- `color` out 2 00 none, 01 red, 10 green, 11 blue
- `valid` out 1 one-cycle strobe, `color`/counts updated this cycle
- `cnt_r`, `cnt_g`, `cnt_b` out CNT_W each: last completed frame's channel counts
- `cnt_c` out CNT_W: clear-channel count (only with COLOR_CLEAR_EN)

## Operation
- `out` passes a 2-flop synchroniser, then a rising-edge detector (previous vs current synced sample); one edge = one count.
- FSM states: IDLE, SETTLE, COUNT, DECIDE. A phase register selects the channel: R (s2=0,s3=0), B (0,1), G (1,1); C (1,0) only with macro.
- IDLE: s2=s3=0. When en=1, go to SETTLE with phase R.
- SETTLE: s2/s3 driven for the current phase; edge counter held at 0. After SETTLE_CYCLES cycles, go to COUNT.
- COUNT: edge counter increments on each detected edge for GATE_CYCLES cycles, saturating at 2^CNT_W−1 (no wrap).
  - At window end, the count is latched into a per-channel holding register.
  - The next phase enters SETTLE; after the last phase, go to DECIDE.
- DECIDE (one cycle):
  - The maximum of R/G/B is found; ties resolve with priority R > G > B.
  - If max < MIN_CNT, color=00; otherwise the winner's code.
  - `color`, `cnt_*` are copied from holding registers and `valid`=1.
  - Next state is SETTLE/phase R if en=1, else IDLE.
- en sampled low in SETTLE or COUNT: abort to IDLE next cycle. Partial counts are discarded; `color`/`cnt_*` hold the previous frame; no valid.
- Edge in the last COUNT cycle is counted. An edge on the cycle the window closes is not carried into the next phase (counter cleared in SETTLE).
- Timers sized ceil(log2(max(GATE_CYCLES,SETTLE_CYCLES)+1)) bits. The edge counter compares against max before increment.

## Timing
- Reset (async assert, sync release via clk): state IDLE, s2=s3=0, color=00, valid=0, all cnt_* = 0, timers/counters 0. Reset mid-frame discards everything.
- en high at cycle t (sampled) → SETTLE from t+1. First valid at t+1+N·(SETTLE_CYCLES+GATE_CYCLES), N = 3 (4 with macro).
- With en held, valid period = N·(SETTLE_CYCLES+GATE_CYCLES)+1 cycles.
- Edge-to-count latency: 3 clk cycles from `out` rising to counter increment.
- `valid` is never high two consecutive cycles. `color` changes only on valid cycles.
- Minimum countable `out` high/low time: 2 clk periods.

## Configuration
- `COLOR_CLEAR_EN` defined: adds fourth phase C after G, port `cnt_c`, and an ambient check. If cnt_c < MIN_CNT, color=00 regardless of R/G/B (sensor covered / off track). N=4.
- Undefined: three phases only; `cnt_c` port absent; classification uses R/G/B and MIN_CNT only.

## Test plan
- Reset: pulse rst_n low mid-COUNT with `out` toggling → all outputs 0 immediately, and no valid until a full frame after release.
- GATE=100, SETTLE=10, MIN_CNT=5, `out` period 4 clk on R phase only (others static) → cnt_r=25, cnt_g=cnt_b=0, color=01, valid at cycle 331 after en.
- Equal 20 edges on all phases → color=01 (tie priority). Only G=20, B=20, R=0 → color=10.
- All channels 4 edges (< MIN_CNT) → color=00, valid still pulses, cnt_* = 4.
- CNT_W=4, 30 edges in window → cnt saturates at 15, no wrap.
- en dropped mid-G COUNT → IDLE, no valid, previous color held. With COLOR_CLEAR_EN and cnt_c=0 → color=00 despite R=25.
